// File: rtl/cache_cmd_dispatch.sv
// cache_cmd_dispatch: FIFO-buffered command dispatcher for N L1 cache channels.
// Optional watchdog built when CACHE_DISPATCH_TIMEOUT_EN is defined.
module cache_cmd_dispatch #(
  parameter int NCH            = 2,
  parameter int ADDR_W         = 60,
  parameter int STAT_W         = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_cmd,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [2:0]            in_ch,
  output logic [NCH-1:0]        cache_write,
  output logic [2:0]            cache_cmd,
  output logic [ADDR_W-1:0]     cache_addr,
  input  logic [NCH-1:0]        cache_processing,
  input  logic [NCH*STAT_W-1:0] st_reads_in,
  input  logic [NCH*STAT_W-1:0] st_writes_in,
  input  logic [NCH*STAT_W-1:0] st_hits_in,
  input  logic [NCH*STAT_W-1:0] st_misses_in,
  input  logic [NCH*STAT_W-1:0] st_total_in,
  output logic [STAT_W-1:0]     st_reads,
  output logic [STAT_W-1:0]     st_writes,
  output logic [STAT_W-1:0]     st_hits,
  output logic [STAT_W-1:0]     st_misses,
  output logic [STAT_W-1:0]     st_total,
  output logic                  busy,
  output logic [31:0]           issued_cnt,
  output logic                  err_bad_ch,
  output logic                  timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] CMD_CLEAR = 3'd3;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t r_state, w_state_n;

  logic [2:0]        r_mem_cmd  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [2:0]        r_mem_ch   [FIFO_DEPTH];
  logic [PW:0]       r_wp, r_rp;

  logic              w_full, w_empty, w_push, w_pop;
  logic [2:0]        w_head_cmd, w_head_ch;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_clear, w_bad;
  logic [NCH-1:0]    w_mask;

  logic [NCH-1:0]    r_write, w_write_n, r_mask;
  logic [2:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_issued;
  logic              r_bad;
  logic              w_load, w_bad_pop, w_done;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[PW] != r_rp[PW]) &&
                   (r_wp[PW-1:0] == r_rp[PW-1:0]);
  assign w_push  = in_valid && !w_full;

  assign w_head_cmd  = r_mem_cmd[r_rp[PW-1:0]];
  assign w_head_addr = r_mem_addr[r_rp[PW-1:0]];
  assign w_head_ch   = r_mem_ch[r_rp[PW-1:0]];
  assign w_clear     = (w_head_cmd == CMD_CLEAR);
  assign w_bad       = !w_clear && (int'(w_head_ch) >= NCH);
  assign w_mask      = w_clear ? '1 : (NCH'(1) << w_head_ch);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wp[PW-1:0]]  <= in_cmd;
      r_mem_addr[r_wp[PW-1:0]] <= in_addr;
      r_mem_ch[r_wp[PW-1:0]]   <= in_ch;
    end
  end

`ifdef CACHE_DISPATCH_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_to_err;
  logic        w_to;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_write_n = r_write;
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_bad_pop = 1'b0;
    w_done    = 1'b0;
`ifdef CACHE_DISPATCH_TIMEOUT_EN
    w_to      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_bad) begin
            w_bad_pop = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_write_n = w_mask;
            w_state_n = S_ACTIVE;
          end
        end
      end
      S_ACTIVE: begin
        // a strobe drops once its channel reports processing
        w_write_n = r_write & ~cache_processing;
        if (r_write == '0 &&
            (cache_processing & r_mask) == '0) begin
          w_done    = 1'b1;
          w_state_n = S_IDLE;
        end
`ifdef CACHE_DISPATCH_TIMEOUT_EN
        else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_to      = 1'b1;
          w_write_n = '0;
          w_state_n = S_IDLE;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= '0;
      r_mask   <= '0;
      r_cmd    <= '0;
      r_addr   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_issued <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_write <= w_write_n;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_load) begin
        r_cmd  <= w_head_cmd;
        r_addr <= w_head_addr;
        r_mask <= w_mask;
      end
      if (w_bad_pop) r_bad <= 1'b1;
      if (w_done)    r_issued <= r_issued + 32'd1;
    end
  end

`ifdef CACHE_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      if (w_load)                   r_to_cnt <= '0;
      else if (r_state == S_ACTIVE) r_to_cnt <= r_to_cnt + 32'd1;
      if (w_to) r_to_err <= 1'b1;
    end
  end
  assign timeout_err = r_to_err;
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = 32'(TIMEOUT_CYCLES);
  assign timeout_err = 1'b0;
`endif

  logic [STAT_W-1:0] w_s_rd, w_s_wr, w_s_hit, w_s_mis, w_s_tot;
  logic [STAT_W-1:0] r_s_rd, r_s_wr, r_s_hit, r_s_mis, r_s_tot;

  always_comb begin
    w_s_rd  = '0;
    w_s_wr  = '0;
    w_s_hit = '0;
    w_s_mis = '0;
    w_s_tot = '0;
    for (int k = 0; k < NCH; k++) begin
      w_s_rd  = w_s_rd  + st_reads_in[k*STAT_W +: STAT_W];
      w_s_wr  = w_s_wr  + st_writes_in[k*STAT_W +: STAT_W];
      w_s_hit = w_s_hit + st_hits_in[k*STAT_W +: STAT_W];
      w_s_mis = w_s_mis + st_misses_in[k*STAT_W +: STAT_W];
      w_s_tot = w_s_tot + st_total_in[k*STAT_W +: STAT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_rd  <= '0;
      r_s_wr  <= '0;
      r_s_hit <= '0;
      r_s_mis <= '0;
      r_s_tot <= '0;
    end else begin
      r_s_rd  <= w_s_rd;
      r_s_wr  <= w_s_wr;
      r_s_hit <= w_s_hit;
      r_s_mis <= w_s_mis;
      r_s_tot <= w_s_tot;
    end
  end

  assign in_ready    = !w_full;
  assign cache_write = r_write;
  assign cache_cmd   = r_cmd;
  assign cache_addr  = r_addr;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign issued_cnt  = r_issued;
  assign err_bad_ch  = r_bad;
  assign st_reads    = r_s_rd;
  assign st_writes   = r_s_wr;
  assign st_hits     = r_s_hit;
  assign st_misses   = r_s_mis;
  assign st_total    = r_s_tot;

endmodule

// File: tb/tb_cache_cmd_dispatch.sv
// tb_cache_cmd_dispatch: directed checks of cache_cmd_dispatch (NCH=2).
// Watchdog checks adapt to CACHE_DISPATCH_TIMEOUT_EN.
module tb_cache_cmd_dispatch;

  localparam int NCH = 2;
  localparam int AW  = 60;
  localparam int SW  = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cmd;
  logic [AW-1:0] in_addr;
  logic [2:0]    in_ch;
  logic [NCH-1:0] cache_write;
  logic [2:0]    cache_cmd;
  logic [AW-1:0] cache_addr;
  logic [NCH-1:0] cache_processing;
  logic [NCH*SW-1:0] st_reads_in, st_writes_in;
  logic [NCH*SW-1:0] st_hits_in, st_misses_in, st_total_in;
  logic [SW-1:0] st_reads, st_writes, st_hits;
  logic [SW-1:0] st_misses, st_total;
  logic          busy;
  logic [31:0]   issued_cnt;
  logic          err_bad_ch;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  cache_cmd_dispatch #(
    .NCH(NCH), .ADDR_W(AW), .STAT_W(SW),
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_addr(in_addr), .in_ch(in_ch),
    .cache_write(cache_write), .cache_cmd(cache_cmd),
    .cache_addr(cache_addr),
    .cache_processing(cache_processing),
    .st_reads_in(st_reads_in), .st_writes_in(st_writes_in),
    .st_hits_in(st_hits_in), .st_misses_in(st_misses_in),
    .st_total_in(st_total_in),
    .st_reads(st_reads), .st_writes(st_writes),
    .st_hits(st_hits), .st_misses(st_misses),
    .st_total(st_total),
    .busy(busy), .issued_cnt(issued_cnt),
    .err_bad_ch(err_bad_ch), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [2:0] c,
                          input logic [2:0] ch,
                          input logic [AW-1:0] a);
    in_cmd   = c;
    in_ch    = ch;
    in_addr  = a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 1", in_ready);
    end
    n_cmp++;
    if (cache_write !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rst_idle: wr %b busy %b want 00 0",
               cache_write, busy);
    end
    n_cmp++;
    if (issued_cnt !== 32'd0 || err_bad_ch !== 1'b0 ||
        timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags: iss %0d bad %b to %b want 0 0 0",
               issued_cnt, err_bad_ch, timeout_err);
    end
    n_cmp++;
    if (cache_addr !== '0 || cache_cmd !== 3'd0 ||
        st_reads !== '0 || st_hits !== '0) begin
      n_err++;
      $display("FAIL rst_regs: addr %h cmd %0d rd %h hit %h want 0",
               cache_addr, cache_cmd, st_reads, st_hits);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    push_cmd(3'd0, 3'd1, 60'h3865837);
    n_cmp++;
    if (cache_write !== 2'b00) begin
      n_err++;
      $display("FAIL rd_early: got %b want 00", cache_write);
    end
    step();
    n_cmp++;
    if (cache_write !== 2'b10 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rd_strobe: wr %b busy %b want 10 1",
               cache_write, busy);
    end
    cache_processing = 2'b10;
    step();
    n_cmp++;
    if (cache_write !== 2'b00) begin
      n_err++;
      $display("FAIL rd_ack: got %b want 00", cache_write);
    end
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1 || issued_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rd_hold: busy %b iss %0d want 1 0",
               busy, issued_cnt);
    end
    cache_processing = 2'b00;
    step();
    n_cmp++;
    if (busy !== 1'b0 || issued_cnt !== 32'd1 ||
        cache_addr !== 60'h3865837 || cache_cmd !== 3'd0) begin
      n_err++;
      $display("FAIL rd_done: busy %b iss %0d addr %h cmd %0d",
               busy, issued_cnt, cache_addr, cache_cmd);
    end
  endtask

  task automatic test_clear();
    push_cmd(3'd3, 3'd0, 60'hC1);
    step();
    n_cmp++;
    if (cache_write !== 2'b11 || cache_cmd !== 3'd3) begin
      n_err++;
      $display("FAIL clr_bcast: wr %b cmd %0d want 11 3",
               cache_write, cache_cmd);
    end
    step();
    cache_processing = 2'b01;
    step();
    n_cmp++;
    if (cache_write !== 2'b10) begin
      n_err++;
      $display("FAIL clr_ch0: got %b want 10", cache_write);
    end
    step();
    cache_processing = 2'b00;
    step();
    step();
    n_cmp++;
    if (cache_write !== 2'b10 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL clr_wait: wr %b busy %b want 10 1",
               cache_write, busy);
    end
    cache_processing = 2'b10;
    step();
    n_cmp++;
    if (cache_write !== 2'b00) begin
      n_err++;
      $display("FAIL clr_ch1: got %b want 00", cache_write);
    end
    step();
    n_cmp++;
    if (busy !== 1'b1 || issued_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL clr_noexit: busy %b iss %0d want 1 1",
               busy, issued_cnt);
    end
    cache_processing = 2'b00;
    step();
    n_cmp++;
    if (busy !== 1'b0 || issued_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL clr_exit: busy %b iss %0d want 0 2",
               busy, issued_cnt);
    end
  endtask

  task automatic test_bad_ch();
    logic seen_wr;
    seen_wr = 1'b0;
    push_cmd(3'd1, 3'd3, 60'hBAD);
    for (int i = 0; i < 4; i++) begin
      step();
      if (cache_write !== 2'b00) seen_wr = 1'b1;
    end
    n_cmp++;
    if (err_bad_ch !== 1'b1 || seen_wr !== 1'b0) begin
      n_err++;
      $display("FAIL bad_flag: err %b strobe %b want 1 0",
               err_bad_ch, seen_wr);
    end
    n_cmp++;
    if (issued_cnt !== 32'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bad_cnt: iss %0d busy %b want 2 0",
               issued_cnt, busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] seen [$];
    logic [NCH-1:0] prev;
    logic acc, f_acc;
    logic [AW-1:0] want;
    int rises;
    rises = 0;
    f_acc = 1'b0;
    push_cmd(3'd1, 3'd0, 60'hA0);
    step();
    n_cmp++;
    if (cache_write !== 2'b01) begin
      n_err++;
      $display("FAIL ff_first: got %b want 01", cache_write);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_cmd  = 3'd1;
      in_ch   = 3'(i % 2);
      in_addr = 60'h100 + 60'(i);
      step();
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ff_full: ready %b want 0", in_ready);
    end
    in_ch   = 3'd0;
    in_addr = 60'h104;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || cache_write !== 2'b01) begin
      n_err++;
      $display("FAIL ff_stall: ready %b wr %b want 0 01",
               in_ready, cache_write);
    end
    prev = cache_write;
    for (int c = 0; c < 200; c++) begin
      if (seen.size() == 5 && !busy && !in_valid) break;
      cache_processing = cache_write;
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        in_valid = 1'b0;
        f_acc = 1'b1;
        n_cmp++;
        if (rises < 1) begin
          n_err++;
          $display("FAIL ff_5th_early: pops %0d want >=1", rises);
        end
      end
      if (prev == '0 && cache_write != '0) begin
        seen.push_back(cache_addr);
        rises++;
      end
      prev = cache_write;
    end
    cache_processing = 2'b00;
    in_valid = 1'b0;
    n_cmp++;
    if (f_acc !== 1'b1 || seen.size() != 5) begin
      n_err++;
      $display("FAIL ff_drain: acc %b issued %0d want 1 5",
               f_acc, seen.size());
    end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      want = 60'h100 + 60'(i);
      n_cmp++;
      if (seen[i] !== want) begin
        n_err++;
        $display("FAIL ff_order%0d: got %h want %h",
                 i, seen[i], want);
      end
    end
    n_cmp++;
    if (issued_cnt !== 32'd8 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ff_cnt: iss %0d busy %b want 8 0",
               issued_cnt, busy);
    end
  endtask

  task automatic test_stats();
    st_hits_in  = {64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    st_reads_in = {64'd20, 64'd10};
    st_total_in = {64'd5, 64'd7};
    n_cmp++;
    if (st_reads !== 64'd0) begin
      n_err++;
      $display("FAIL st_lat: got %0d want 0", st_reads);
    end
    step();
    n_cmp++;
    if (st_hits !== 64'd1) begin
      n_err++;
      $display("FAIL st_wrap: got %h want 1", st_hits);
    end
    n_cmp++;
    if (st_reads !== 64'd30 || st_total !== 64'd12 ||
        st_misses !== 64'd0 || st_writes !== 64'd0) begin
      n_err++;
      $display("FAIL st_sum: rd %0d tot %0d mis %0d wr %0d",
               st_reads, st_total, st_misses, st_writes);
    end
  endtask

  task automatic test_reset_mid();
    push_cmd(3'd1, 3'd0, 60'h55);
    step();
    n_cmp++;
    if (cache_write !== 2'b01) begin
      n_err++;
      $display("FAIL rm_pre: got %b want 01", cache_write);
    end
    push_cmd(3'd0, 3'd1, 60'h66);
    rst = 1'b1;
    step();
    n_cmp++;
    if (cache_write !== 2'b00 || busy !== 1'b0 ||
        issued_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rm_edge: wr %b busy %b iss %0d want 00 0 0",
               cache_write, busy, issued_cnt);
    end
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (cache_write !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rm_discard: wr %b busy %b want 00 0",
               cache_write, busy);
    end
  endtask

  task automatic test_timeout();
    push_cmd(3'd0, 3'd1, 60'h77);
    step();
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (timeout_err !== 1'b0 || cache_write !== 2'b10) begin
      n_err++;
      $display("FAIL to_pre: to %b wr %b want 0 10",
               timeout_err, cache_write);
    end
    step();
`ifdef CACHE_DISPATCH_TIMEOUT_EN
    n_cmp++;
    if (timeout_err !== 1'b1 || cache_write !== 2'b00 ||
        busy !== 1'b0 || issued_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL to_fire: to %b wr %b busy %b iss %0d",
               timeout_err, cache_write, busy, issued_cnt);
    end
`else
    n_cmp++;
    if (timeout_err !== 1'b0 || cache_write !== 2'b10) begin
      n_err++;
      $display("FAIL to_off: to %b wr %b want 0 10",
               timeout_err, cache_write);
    end
    cache_processing = 2'b10;
    step();
    cache_processing = 2'b00;
    step();
    n_cmp++;
    if (issued_cnt !== 32'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_late: iss %0d busy %b want 1 0",
               issued_cnt, busy);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_cmd = 3'd0;
    in_addr = '0;
    in_ch = 3'd0;
    cache_processing = '0;
    st_reads_in = '0;
    st_writes_in = '0;
    st_hits_in = '0;
    st_misses_in = '0;
    st_total_in = '0;
    test_reset();
    test_single_read();
    test_clear();
    test_bad_ch();
    test_fifo_full();
    test_stats();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
